spart_rx: RTL and testbench

- Serial receive engine feeding the SPART bus interface. Directly upstream of the register that the driver reads.
- Synchronises and oversamples the rxd line, frames 8N1 characters (LSB first), and presents the completed byte with a receive-data-available (rda) flag.
- Reports framing and overrun errors.
- Timing comes from an external 16x baud-tick enable supplied by the SPART baud generator.

---
 rtl/spart_rx.sv | 151 +++++++++++++++
 tb/tb_spart_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// SPART receive engine: synchronises rxd, frames 8N1 characters on the 16x
// baud enable, and holds the last good byte with rda/frame_err/overrun flags.
module spart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 baud_en,
  input  logic                 rd_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rda_q, rda_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(rxd);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rda_d   = rda_q;
    fe_d    = fe_q;
    ov_d    = ov_q;

    // A bus read clears the flags first so a same-cycle completion can re-set them.
    if (rd_clr) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end

    if (baud_en) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (!rxs) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d                = '0;
            shift_d               = shift_q >> 1;
            shift_d[DATA_BITS-1]  = rxs;
            bit_d                 = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxs) begin
              data_d  = shift_q;
              ov_d    = ov_d | (rda_q & ~rd_clr);
              rda_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = S_BRK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_BRK: begin
          // Held-low line: wait for idle so a break reports a single error.
          if (rxs) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_data   = data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: baud_en every 4 clks (one bit = 64 clks), frames
// aligned to a baud tick so the stop-bit sample lands 612 clks into the frame.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       baud_en = 1'b0;
  logic       rd_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fe_rises = 0;
  logic fe_prev = 1'b0;

  logic       pre_rda, post_rda;
  logic [7:0] rst_data;
  logic [2:0] rst_flags;

  spart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .baud_en(baud_en), .rd_clr(rd_clr),
    .rx_data(rx_data), .rda(rda), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: advance at the falling edge and regenerate baud_en.
  task automatic step();
    @(negedge clk);
    cyc++;
    baud_en = ((cyc % 4) == 0);
    if (frame_err === 1'b1 && fe_prev !== 1'b1) fe_rises++;
    fe_prev = frame_err;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clr();
    step();
    rd_clr = 1'b1;
    step();
    rd_clr = 1'b0;
  endtask

  // t=0 coincides with a baud tick; the stop sample is the edge after t=612.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at,
                            input int rst_at);
    while ((cyc % 4) != 3) step();
    for (int t = 0; t < 640; t++) begin
      step();
      if (t < 64)       rxd = 1'b0;
      else if (t < 576) rxd = d[(t - 64) / 64];
      else              rxd = stop;
      rd_clr = (t == clr_at);
      if (t == 612) pre_rda = rda;
      if (t == 613) post_rda = rda;
      if (rst_at >= 0 && t == rst_at) begin
        #2 rst_n = 1'b0;
      end
      if (rst_at >= 0 && t == rst_at + 4) begin
        rst_data  = rx_data;
        rst_flags = {rda, frame_err, overrun};
      end
      if (rst_at >= 0 && t == rst_at + 8) rst_n = 1'b1;
    end
    rd_clr = 1'b0;
    rxd    = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", rx_data); end
    tests++; if ({rda, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {rda, frame_err, overrun}); end
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b1;
    idle(40);
    tests++; if ({rda, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL idle_flags got %b want 000", {rda, frame_err, overrun}); end
  endtask

  task automatic test_good_byte();
    send_frame(8'h65, 1'b1, -1, -1);
    tests++; if (pre_rda !== 1'b0 || post_rda !== 1'b1) begin fails++; $display("FAIL good_rda_timing got pre=%b post=%b want pre=0 post=1", pre_rda, post_rda); end
    tests++; if (rx_data !== 8'h65) begin fails++; $display("FAIL good_data got %h want 65", rx_data); end
    tests++; if ({rda, frame_err, overrun} !== 3'b100) begin fails++; $display("FAIL good_flags got %b want 100", {rda, frame_err, overrun}); end
    pulse_clr();
    tests++; if (rda !== 1'b0 || rx_data !== 8'h65) begin fails++; $display("FAIL good_clr got rda=%b data=%h want rda=0 data=65", rda, rx_data); end
  endtask

  task automatic test_glitch();
    while ((cyc % 4) != 3) step();
    for (int t = 0; t < 16; t++) begin step(); rxd = 1'b0; end
    idle(100);
    tests++; if ({rda, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL glitch_flags got %b want 000", {rda, frame_err, overrun}); end
    send_frame(8'hA6, 1'b1, -1, -1);
    tests++; if (rda !== 1'b1 || rx_data !== 8'hA6) begin fails++; $display("FAIL glitch_next got rda=%b data=%h want rda=1 data=a6", rda, rx_data); end
    pulse_clr();
  endtask

  task automatic test_frame_err();
    fe_rises = 0;
    send_frame(8'h59, 1'b0, -1, -1);
    rxd = 1'b0;
    for (int i = 0; i < 256; i++) step();
    idle(64);
    tests++; if (fe_rises !== 1) begin fails++; $display("FAIL fe_once got %0d rises want 1", fe_rises); end
    tests++; if ({rda, frame_err, overrun} !== 3'b010 || rx_data !== 8'hA6) begin fails++; $display("FAIL fe_state got flags=%b data=%h want 010 a6", {rda, frame_err, overrun}, rx_data); end
    send_frame(8'h3C, 1'b1, -1, -1);
    tests++; if ({rda, frame_err} !== 2'b11 || rx_data !== 8'h3C) begin fails++; $display("FAIL fe_next got rda/fe=%b data=%h want 11 3c", {rda, frame_err}, rx_data); end
    pulse_clr();
    tests++; if ({rda, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL fe_clr got %b want 000", {rda, frame_err, overrun}); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    tests++; if ({rda, frame_err, overrun} !== 3'b101 || rx_data !== 8'h22) begin fails++; $display("FAIL overrun got flags=%b data=%h want 101 22", {rda, frame_err, overrun}, rx_data); end
    pulse_clr();
    tests++; if ({rda, overrun} !== 2'b00 || rx_data !== 8'h22) begin fails++; $display("FAIL overrun_clr got rda/ov=%b data=%h want 00 22", {rda, overrun}, rx_data); end
  endtask

  task automatic test_coincidence();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 612, -1);
    tests++; if ({rda, frame_err, overrun} !== 3'b100 || rx_data !== 8'h22) begin fails++; $display("FAIL coinc_good got flags=%b data=%h want 100 22", {rda, frame_err, overrun}, rx_data); end
    tests++; if (post_rda !== 1'b1) begin fails++; $display("FAIL coinc_good_rda got %b want 1", post_rda); end
    send_frame(8'h77, 1'b0, 612, -1);
    idle(64);
    tests++; if ({rda, frame_err, overrun} !== 3'b010 || rx_data !== 8'h22) begin fails++; $display("FAIL coinc_bad got flags=%b data=%h want 010 22", {rda, frame_err, overrun}, rx_data); end
    pulse_clr();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h5A, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, 280);
    tests++; if (rst_data !== 8'h00 || rst_flags !== 3'b000) begin fails++; $display("FAIL rst_during got data=%h flags=%b want 00 000", rst_data, rst_flags); end
    idle(64);
    tests++; if (rx_data !== 8'h00 || {rda, frame_err, overrun} !== 3'b000) begin fails++; $display("FAIL rst_after got data=%h flags=%b want 00 000", rx_data, {rda, frame_err, overrun}); end
    send_frame(8'h81, 1'b1, -1, -1);
    tests++; if (rx_data !== 8'h81 || {rda, frame_err, overrun} !== 3'b100) begin fails++; $display("FAIL rst_next got data=%h flags=%b want 81 100", rx_data, {rda, frame_err, overrun}); end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_coincidence();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
